ecc_scalar_mul_ctrl: RTL and testbench

- Sequencer for elliptic-curve scalar multiplication Q = k·P over GF(p), using left-to-right double-and-add.
- Does no field arithmetic itself; drives one external Jacobian point-operation unit (jacob_add plus doubling mode) through an en/flag handshake.
- Holds the accumulator point in Jacobian coordinates.
- Sits between the top-level ECC command logic and the point-operation datapath.

---
 rtl/ecc_pkg.sv | 21 ++
 rtl/ecc_scalar_mul_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_ecc_scalar_mul_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_pkg.sv
// Shared types and constants for the ECC scalar-multiplication sequencer.
package ecc_pkg;

  localparam int ECC_WIDTH = 256;
  localparam int ECC_KBITS = 256;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_DBL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DBL,
    ST_DBL_W,
    ST_ADD,
    ST_ADD_W,
    ST_NXT,
    ST_FIN
  } state_e;

endpackage

// File: rtl/ecc_scalar_mul_ctrl.sv
// Left-to-right double-and-add sequencer driving an external Jacobian point unit.
// Define ECC_OP_TIMEOUT_EN to add a per-operation watchdog that aborts with err.
import ecc_pkg::*;

module ecc_scalar_mul_ctrl #(
  parameter int WIDTH   = ECC_WIDTH,
  parameter int KBITS   = ECC_KBITS,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] p,
  input  logic [KBITS-1:0] k,
  input  logic [WIDTH-1:0] px,
  input  logic [WIDTH-1:0] py,
  output logic             busy,
  output logic             done,
  output logic             inf,
  output logic [WIDTH-1:0] qx,
  output logic [WIDTH-1:0] qy,
  output logic [WIDTH-1:0] qz,
  output logic             op_en,
  output logic             op_dbl,
  output logic [WIDTH-1:0] op_p,
  output logic [WIDTH-1:0] op_x1,
  output logic [WIDTH-1:0] op_y1,
  output logic [WIDTH-1:0] op_z1,
  output logic [WIDTH-1:0] op_x2,
  output logic [WIDTH-1:0] op_y2,
  output logic [WIDTH-1:0] op_z2,
  input  logic [WIDTH-1:0] op_x3,
  input  logic [WIDTH-1:0] op_y3,
  input  logic [WIDTH-1:0] op_z3,
  input  logic             op_flag,
  output logic             err
);

  localparam int IW = (KBITS > 1) ? $clog2(KBITS) : 1;

  state_e           state_q, state_d;
  logic [KBITS-1:0] k_q, k_d;
  logic [WIDTH-1:0] bx_q, bx_d, by_q, by_d, bz_q, bz_d;
  logic [WIDTH-1:0] ax_q, ax_d, ay_q, ay_d, az_q, az_d;
  logic [WIDTH-1:0] qx_q, qx_d, qy_q, qy_d, qz_q, qz_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             inf_q, inf_d, err_q, err_d;
  logic             timeout_hit;
  logic             idx_zero;
  logic             cur_bit;

  assign idx_zero = (idx_q == '0);
  assign cur_bit  = k_q[idx_q];

`ifdef ECC_OP_TIMEOUT_EN
  logic [31:0] wdog_q;

  // Cleared during the launch cycle so the first wait cycle counts as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q <= '0;
    end else if (state_q == ST_DBL || state_q == ST_ADD) begin
      wdog_q <= '0;
    end else if (state_q == ST_DBL_W || state_q == ST_ADD_W) begin
      wdog_q <= wdog_q + 32'd1;
    end
  end

  assign timeout_hit = (wdog_q == 32'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      bz_q    <= '0;
      ax_q    <= '0;
      ay_q    <= '0;
      az_q    <= '0;
      qx_q    <= '0;
      qy_q    <= '0;
      qz_q    <= '0;
      idx_q   <= '0;
      inf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      bz_q    <= bz_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      az_q    <= az_d;
      qx_q    <= qx_d;
      qy_q    <= qy_d;
      qz_q    <= qz_d;
      idx_q   <= idx_d;
      inf_q   <= inf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SCAN;
      ST_SCAN: begin
        if (cur_bit)       state_d = idx_zero ? ST_FIN : ST_DBL;
        else if (idx_zero) state_d = ST_FIN;
      end
      ST_DBL:   state_d = ST_DBL_W;
      ST_DBL_W: begin
        if (op_flag)          state_d = cur_bit ? ST_ADD : ST_NXT;
        else if (timeout_hit) state_d = ST_FIN;
      end
      ST_ADD:   state_d = ST_ADD_W;
      ST_ADD_W: begin
        if (op_flag)          state_d = ST_NXT;
        else if (timeout_hit) state_d = ST_FIN;
      end
      ST_NXT:   state_d = idx_zero ? ST_FIN : ST_DBL;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    k_d   = k_q;
    bx_d  = bx_q;
    by_d  = by_q;
    bz_d  = bz_q;
    ax_d  = ax_q;
    ay_d  = ay_q;
    az_d  = az_q;
    idx_d = idx_q;
    inf_d = inf_q;
    err_d = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          k_d   = k;
          bx_d  = px;
          by_d  = py;
          bz_d  = WIDTH'(1);
          idx_d = IW'(KBITS - 1);
          inf_d = 1'b0;
          err_d = 1'b0;
        end
      end
      ST_SCAN: begin
        if (cur_bit) begin
          ax_d = bx_q;
          ay_d = by_q;
          az_d = bz_q;
        end
        if (!idx_zero)     idx_d = idx_q - IW'(1);
        else if (!cur_bit) inf_d = 1'b1;
      end
      ST_DBL_W, ST_ADD_W: begin
        if (op_flag) begin
          ax_d = op_x3;
          ay_d = op_y3;
          az_d = op_z3;
        end else if (timeout_hit) begin
          err_d = 1'b1;
        end
      end
      ST_NXT:  if (!idx_zero) idx_d = idx_q - IW'(1);
      default: ;
    endcase
  end

  // Result registers load on the way into FIN so they are valid alongside done.
  always_comb begin
    qx_d = qx_q;
    qy_d = qy_q;
    qz_d = qz_q;
    if (state_d == ST_FIN) begin
      qx_d = (inf_d || err_d) ? '0 : ax_d;
      qy_d = (inf_d || err_d) ? '0 : ay_d;
      qz_d = (inf_d || err_d) ? '0 : az_d;
    end
  end

  always_comb begin
    busy   = (state_q != ST_IDLE);
    done   = (state_q == ST_FIN);
    op_en  = (state_q == ST_DBL) || (state_q == ST_ADD);
    op_dbl = ((state_q == ST_DBL) || (state_q == ST_DBL_W)) ? OP_DBL : OP_ADD;
  end

  assign inf   = inf_q;
  assign err   = err_q;
  assign qx    = qx_q;
  assign qy    = qy_q;
  assign qz    = qz_q;
  assign op_p  = p;
  assign op_x1 = ax_q;
  assign op_y1 = ay_q;
  assign op_z1 = az_q;
  assign op_x2 = bx_q;
  assign op_y2 = by_q;
  assign op_z2 = bz_q;

endmodule

// File: tb/tb_ecc_scalar_mul_ctrl.sv
// Scoreboard bench for ecc_scalar_mul_ctrl with a mock point unit (add: x1+x2, dbl: 2*x1).
module tb_ecc_scalar_mul_ctrl;

  localparam int W  = 256;
  localparam int KB = 256;

  typedef struct {
    logic [W-1:0] qx, qy, qz;
    logic         inf, err;
    int           ndbl, nadd;
    logic [15:0]  seq;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [W-1:0]  p, px, py;
  logic [KB-1:0] k;
  logic          busy, done, inf, err, op_en, op_dbl, op_flag;
  logic [W-1:0]  qx, qy, qz, op_p;
  logic [W-1:0]  op_x1, op_y1, op_z1, op_x2, op_y2, op_z2, op_x3, op_y3, op_z3;

  exp_t         sb_q[$];
  int           checks = 0;
  int           fails  = 0;
  int           cyc_cnt = 0;
  int           mock_n = 1;
  bit           mock_silent = 1'b0;
  int           n_dbl = 0;
  int           n_add = 0;
  logic [15:0]  seq_log = '0;
  int           last_op_cyc = 0;
  int           done_cyc = 0;

  always #5 clk = ~clk;

  ecc_scalar_mul_ctrl #(.WIDTH(W), .KBITS(KB), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .p(p), .k(k), .px(px), .py(py),
    .busy(busy), .done(done), .inf(inf), .qx(qx), .qy(qy), .qz(qz),
    .op_en(op_en), .op_dbl(op_dbl), .op_p(op_p),
    .op_x1(op_x1), .op_y1(op_y1), .op_z1(op_z1),
    .op_x2(op_x2), .op_y2(op_y2), .op_z2(op_z2),
    .op_x3(op_x3), .op_y3(op_y3), .op_z3(op_z3),
    .op_flag(op_flag), .err(err)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc_cnt++;
    end
  end

  // Mock point unit: one operation at a time, replies mock_n cycles after op_en.
  initial begin
    logic [W-1:0] x1, y1, z1, x2;
    logic         dbl;
    op_flag = 1'b0;
    op_x3 = '0;
    op_y3 = '0;
    op_z3 = '0;
    forever begin
      @(negedge clk);
      if (op_en === 1'b1) begin
        x1 = op_x1; y1 = op_y1; z1 = op_z1; x2 = op_x2; dbl = op_dbl;
        if (dbl) n_dbl++; else n_add++;
        seq_log = {seq_log[14:0], dbl};
        last_op_cyc = cyc_cnt;
        if (!mock_silent) begin
          repeat (mock_n) @(posedge clk);
          #1;
          if (busy === 1'b1) chk("op_dbl_stable", op_dbl, dbl);
          op_x3 = dbl ? (x1 + x1) : (x1 + x2);
          op_y3 = y1;
          op_z3 = z1;
          op_flag = 1'b1;
          @(posedge clk);
          #1 op_flag = 1'b0;
        end
      end
    end
  end

  // Monitor: every done pulse is matched against the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done: got done=1 expected no result pending");
        end else begin
          e = sb_q.pop_front();
          chk("qx", qx, e.qx);
          chk("qy", qy, e.qy);
          chk("qz", qz, e.qz);
          chk("inf", inf, e.inf);
          chk("err", err, e.err);
          chk("n_dbl", n_dbl, e.ndbl);
          chk("n_add", n_add, e.nadd);
          chk("op_seq", seq_log, e.seq);
        end
      end
    end
  end

  task automatic check_reset();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_inf", inf, 0);
    chk("rst_err", err, 0);
    chk("rst_op_en", op_en, 0);
    chk("rst_op_dbl", op_dbl, 0);
    chk("rst_qx", qx, 0);
    chk("rst_qz", qz, 0);
    chk("rst_op_x1", op_x1, 0);
    chk("rst_op_z2", op_z2, 0);
  endtask

  // Called at a negedge; start is sampled at the following posedge.
  task automatic run(input logic [KB-1:0] kk, input logic [W-1:0] pxv, input logic [W-1:0] pyv,
                     input exp_t e, input int budget, input bit glitch);
    int cyc;
    int drops;
    bit got;
    cyc = 0; drops = 0; got = 1'b0;
    n_dbl = 0; n_add = 0; seq_log = '0;
    sb_q.push_back(e);
    k = kk; px = pxv; py = pyv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (!got && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (busy !== 1'b1) drops++;
      if (glitch && cyc == 20) begin
        start = 1'b1;
        k = ~kk;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) got = 1'b1;
    end
    done_cyc = cyc_cnt;
    chk("done_in_budget", got, 1);
    chk("busy_held", drops, 0);
    // A start presented while done is high must be ignored.
    start = 1'b1;
    k = kk ^ 1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("start_at_done_ignored", busy, 0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got simulation still running expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [KB-1:0] ones;
    int waited;
    ones = '1;
    rst = 1'b1; start = 1'b0; k = '0; px = '0; py = '0; p = 256'hFFFF_FFF1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_reset();
    chk("op_p_forward", op_p, 256'hFFFF_FFF1);
    @(negedge clk);

    mock_n = 2;
    run('0, 256'd5, 256'd7, '{qx:0, qy:0, qz:0, inf:1, err:0, ndbl:0, nadd:0, seq:16'h0}, KB + 2, 1'b0);
    run(256'd1, 256'd5, 256'd7, '{qx:5, qy:7, qz:1, inf:0, err:0, ndbl:0, nadd:0, seq:16'h0}, 400, 1'b0);
    mock_n = 3;
    run(256'd13, 256'd1, 256'd3, '{qx:13, qy:3, qz:1, inf:0, err:0, ndbl:3, nadd:2, seq:16'h0016}, 400, 1'b1);
    mock_n = 1;
    run(ones, 256'd1, 256'd2, '{qx:ones, qy:2, qz:1, inf:0, err:0, ndbl:255, nadd:255, seq:16'hAAAA}, 5000, 1'b0);

    // Reset during the second doubling wait; the late op_flag must be ignored.
    mock_n = 3;
    n_dbl = 0; n_add = 0; seq_log = '0;
    k = 256'd13; px = 256'd1; py = 256'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waited = 0;
    while (n_dbl + n_add < 3 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    chk("third_op_reached", n_dbl + n_add, 3);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check_reset();
    repeat (8) @(negedge clk);
    chk("stale_flag_busy", busy, 0);
    chk("stale_flag_qx", qx, 0);
    run(256'd6, 256'd1, 256'd9, '{qx:6, qy:9, qz:1, inf:0, err:0, ndbl:2, nadd:1, seq:16'h0005}, 400, 1'b0);

`ifdef ECC_OP_TIMEOUT_EN
    mock_silent = 1'b1;
    run(256'd2, 256'd1, 256'd4, '{qx:0, qy:0, qz:0, inf:0, err:1, ndbl:1, nadd:0, seq:16'h0001}, 400, 1'b0);
    chk("timeout_latency", done_cyc - last_op_cyc, 17);
    chk("err_held", err, 1);
    mock_silent = 1'b0;
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
